// File: rtl/cpu_seq_pkg.sv
// Shared constants and types for the cpu_sequencer control unit:
// opcodes, MOVE destinations, bus source codes and the FSM state type.
package cpu_seq_pkg;

   localparam logic [1:0] OP_MOVE = 2'b00;
   localparam logic [1:0] OP_ALU  = 2'b01;
   localparam logic [1:0] OP_JUMP = 2'b10;
   localparam logic [1:0] OP_HALT = 2'b11;

   localparam logic [1:0] DEST_NONE = 2'b00;
   localparam logic [1:0] DEST_R1   = 2'b01;
   localparam logic [1:0] DEST_R2   = 2'b10;
   localparam logic [1:0] DEST_BOTH = 2'b11;

   localparam logic [7:0] HALT_WORD = 8'hC0;

   localparam logic [2:0] BUS_SW   = 3'b000;
   localparam logic [2:0] BUS_ROUT = 3'b011;
   localparam logic [2:0] BUS_IMM3 = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic [1:0] opcode_of(input logic [7:0] instr);
      return instr[7:6];
   endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Program store for cpu_sequencer: flop array with synchronous write,
// asynchronous read, and every word reset to HALT.
module seq_prog_mem
   import cpu_seq_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             we,
   input  logic [3:0]       waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [3:0]       raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= WIDTH'(HALT_WORD);
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_sequencer.sv
// Two-cycle FETCH/EXEC microsequencer driving datapath controls from a
// 16-word program. Optional single-step support under `SEQ_STEP_EN.
module cpu_sequencer
   import cpu_seq_pkg::*;
#(
   parameter int PROG_DEPTH = 16,
   parameter int INSTR_W    = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               prog_we,
   input  logic [3:0]         prog_addr,
   input  logic [INSTR_W-1:0] prog_data,
   input  logic               start,
`ifdef SEQ_STEP_EN
   input  logic               step_mode,
   input  logic               step,
`endif
   output logic [2:0]         bus_selector,
   output logic [1:0]         alu_control,
   output logic               r1_enable,
   output logic               r2_enable,
   output logic               rout_enable,
   output logic [3:0]         pc,
   output logic               busy,
   output logic               done
);

   state_t             state, next_state;
   logic [3:0]         pc_next;
   logic [INSTR_W-1:0] ir;
   logic [INSTR_W-1:0] mem_word;
   logic               mem_we;
   logic               fetch_go;
   logic [1:0]         op;

   // Program loads are only accepted while the sequencer is not running.
   assign mem_we = prog_we && ((state == ST_IDLE) || (state == ST_DONE));
   assign op     = opcode_of(ir[7:0]);

`ifdef SEQ_STEP_EN
   assign fetch_go = !step_mode || step;
`else
   assign fetch_go = 1'b1;
`endif

   seq_prog_mem #(
      .DEPTH (PROG_DEPTH),
      .WIDTH (INSTR_W)
   ) u_mem (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (mem_we),
      .waddr   (prog_addr),
      .wdata   (prog_data),
      .raddr   (pc),
      .rdata   (mem_word)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         pc    <= 4'd0;
         ir    <= INSTR_W'(HALT_WORD);
      end else begin
         state <= next_state;
         pc    <= pc_next;
         if ((state == ST_FETCH) && fetch_go) begin
            ir <= mem_word;
         end
      end
   end

   always_comb begin
      next_state = state;
      pc_next    = pc;
      case (state)
         ST_IDLE: begin
            if (start) begin
               next_state = ST_FETCH;
               pc_next    = 4'd0;
            end
         end
         ST_FETCH: begin
            if (fetch_go) begin
               next_state = ST_EXEC;
            end
         end
         ST_EXEC: begin
            // HALT leaves pc on its own address so it stays visible in DONE.
            case (op)
               OP_JUMP: begin
                  pc_next    = ir[3:0];
                  next_state = ST_FETCH;
               end
               OP_HALT: begin
                  next_state = ST_DONE;
               end
               default: begin
                  pc_next    = pc + 4'd1;
                  next_state = ST_FETCH;
               end
            endcase
         end
         ST_DONE: begin
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      bus_selector = 3'b000;
      alu_control  = 2'b00;
      r1_enable    = 1'b0;
      r2_enable    = 1'b0;
      rout_enable  = 1'b0;
      busy         = (state == ST_FETCH) || (state == ST_EXEC);
      done         = (state == ST_DONE);
      if (state == ST_EXEC) begin
         case (op)
            OP_MOVE: begin
               bus_selector = ir[5:3];
               r1_enable    = (ir[1:0] == DEST_R1) || (ir[1:0] == DEST_BOTH);
               r2_enable    = (ir[1:0] == DEST_R2) || (ir[1:0] == DEST_BOTH);
            end
            OP_ALU: begin
               alu_control = ir[1:0];
               rout_enable = 1'b1;
            end
            default: begin
               bus_selector = 3'b000;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer; define SEQ_STEP_EN to
// also exercise single-step mode.
module tb_cpu_sequencer;

   logic       clk;
   logic       reset_n;
   logic       prog_we;
   logic [3:0] prog_addr;
   logic [7:0] prog_data;
   logic       start;
`ifdef SEQ_STEP_EN
   logic       step_mode;
   logic       step;
`endif
   logic [2:0] bus_selector;
   logic [1:0] alu_control;
   logic       r1_enable;
   logic       r2_enable;
   logic       rout_enable;
   logic [3:0] pc;
   logic       busy;
   logic       done;

   int tests_run = 0;
   int tests_failed = 0;

   cpu_sequencer #(
      .PROG_DEPTH (16),
      .INSTR_W    (8)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .prog_we      (prog_we),
      .prog_addr    (prog_addr),
      .prog_data    (prog_data),
      .start        (start),
`ifdef SEQ_STEP_EN
      .step_mode    (step_mode),
      .step         (step),
`endif
      .bus_selector (bus_selector),
      .alu_control  (alu_control),
      .r1_enable    (r1_enable),
      .r2_enable    (r2_enable),
      .rout_enable  (rout_enable),
      .pc           (pc),
      .busy         (busy),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control word layout: {busy, done, sel[2:0], alu[1:0], r1, r2, rout}.
   function automatic logic [9:0] ctl(input logic b, input logic d, input logic [2:0] s,
                                      input logic [1:0] a, input logic e1, input logic e2,
                                      input logic eo);
      return {b, d, s, a, e1, e2, eo};
   endfunction

   function automatic logic [9:0] observed();
      return {busy, done, bus_selector, alu_control, r1_enable, r2_enable, rout_enable};
   endfunction

   task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      start   = 1'b0;
      prog_we = 1'b0;
      next_cycle();
      reset_n = 1'b1;
      check_output("reset_ctl", 32'(observed()), 32'(ctl(0, 0, 3'd0, 2'd0, 0, 0, 0)));
      check_output("reset_pc", 32'(pc), 32'd0);
   endtask

   task automatic write_word(input logic [3:0] addr, input logic [7:0] data);
      prog_we   = 1'b1;
      prog_addr = addr;
      prog_data = data;
      next_cycle();
      prog_we   = 1'b0;
   endtask

   // Leaves the bench sampling cycle 1 (the first FETCH).
   task automatic start_run();
      start = 1'b1;
      next_cycle();
      start = 1'b0;
   endtask

   logic [9:0] exec_exp [8];
   logic [7:0] prog [9];
   logic [9:0] fetch_ctl;
   logic [9:0] done_ctl;

   initial begin
      reset_n   = 1'b0;
      prog_we   = 1'b0;
      prog_addr = 4'd0;
      prog_data = 8'd0;
      start     = 1'b0;
`ifdef SEQ_STEP_EN
      step_mode = 1'b0;
      step      = 1'b0;
`endif
      fetch_ctl = ctl(1, 0, 3'd0, 2'd0, 0, 0, 0);
      done_ctl  = ctl(0, 1, 3'd0, 2'd0, 0, 0, 0);

      // Empty program: HALT straight away.
      apply_reset();
      start_run();
      for (int c = 1; c <= 4; c++) begin
         if (c == 3) check_output($sformatf("empty_c%0d", c), 32'(observed()), 32'(done_ctl));
         else if (c == 4) check_output($sformatf("empty_c%0d", c), 32'(observed()), 32'd0);
         else check_output($sformatf("empty_c%0d", c), 32'(observed()), 32'(fetch_ctl));
         if (c < 4) next_cycle();
      end

      // Mixed MOVE/ALU program; start held high while running must be ignored.
      prog = '{8'h01, 8'h2A, 8'h40, 8'h1A, 8'h41, 8'h19, 8'h43, 8'h19, 8'hC0};
      exec_exp[0] = ctl(1, 0, 3'd0, 2'd0, 1, 0, 0);
      exec_exp[1] = ctl(1, 0, 3'd5, 2'd0, 0, 1, 0);
      exec_exp[2] = ctl(1, 0, 3'd0, 2'd0, 0, 0, 1);
      exec_exp[3] = ctl(1, 0, 3'd3, 2'd0, 0, 1, 0);
      exec_exp[4] = ctl(1, 0, 3'd0, 2'd1, 0, 0, 1);
      exec_exp[5] = ctl(1, 0, 3'd3, 2'd0, 1, 0, 0);
      exec_exp[6] = ctl(1, 0, 3'd0, 2'd3, 0, 0, 1);
      exec_exp[7] = ctl(1, 0, 3'd3, 2'd0, 1, 0, 0);
      apply_reset();
      for (int i = 0; i < 9; i++) write_word(4'(i), prog[i]);
      start = 1'b1;
      next_cycle();
      for (int c = 1; c <= 20; c++) begin
         if (c == 19) begin
            check_output("prog_done", 32'(observed()), 32'(done_ctl));
            check_output("prog_done_pc", 32'(pc), 32'd8);
         end else if (c == 20) begin
            check_output("prog_idle", 32'(observed()), 32'd0);
         end else if ((c % 2) == 1 || c == 18) begin
            check_output($sformatf("prog_c%0d", c), 32'(observed()), 32'(fetch_ctl));
         end else begin
            check_output($sformatf("prog_c%0d", c), 32'(observed()), 32'(exec_exp[c/2-1]));
            check_output($sformatf("prog_pc_c%0d", c), 32'(pc), 32'(c/2-1));
         end
         if (c == 18) start = 1'b0;
         if (c < 20) next_cycle();
      end

      // MOVE R1 / JUMP 0 loop, then reset mid-EXEC with start and prog_we asserted.
      apply_reset();
      write_word(4'd0, 8'h01);
      write_word(4'd1, 8'h80);
      start_run();
      for (int c = 1; c <= 22; c++) begin
         check_output($sformatf("loop_r1_c%0d", c), 32'(r1_enable), 32'((c % 4) == 2));
         if (c < 22) next_cycle();
      end
      reset_n   = 1'b0;
      start     = 1'b1;
      prog_we   = 1'b1;
      prog_addr = 4'd0;
      prog_data = 8'h41;
      next_cycle();
      reset_n = 1'b1;
      start   = 1'b0;
      prog_we = 1'b0;
      check_output("midexec_reset_ctl", 32'(observed()), 32'd0);
      check_output("midexec_reset_pc", 32'(pc), 32'd0);
      start_run();
      next_cycle();
      check_output("post_reset_word0", 32'(observed()), 32'(fetch_ctl));
      next_cycle();
      check_output("post_reset_done", 32'(observed()), 32'(done_ctl));

      // Straight-line program ending in JUMP-to-self; write attempt while busy.
      apply_reset();
      for (int i = 0; i < 15; i++) write_word(4'(i), 8'h01);
      write_word(4'd15, 8'h8F);
      start_run();
      for (int c = 1; c <= 40; c++) begin
         check_output($sformatf("wrap_pc_c%0d", c), 32'(pc), 32'((c <= 32) ? (c - 1) / 2 : 15));
         if (c == 10) begin
            prog_we   = 1'b1;
            prog_addr = 4'd15;
            prog_data = 8'hC0;
         end
         if (c == 11) prog_we = 1'b0;
         if (c < 40) next_cycle();
      end
      check_output("wrap_still_busy", 32'(observed()), 32'(fetch_ctl));

      // Write and start in the same IDLE cycle: first FETCH sees the new word.
      apply_reset();
      prog_we   = 1'b1;
      prog_addr = 4'd0;
      prog_data = 8'h41;
      start     = 1'b1;
      next_cycle();
      prog_we = 1'b0;
      start   = 1'b0;
      next_cycle();
      check_output("same_cycle_alu", 32'(observed()), 32'(ctl(1, 0, 3'd0, 2'd1, 0, 0, 1)));
      next_cycle();
      next_cycle();
      next_cycle();
      check_output("same_cycle_done", 32'(observed()), 32'(done_ctl));

`ifdef SEQ_STEP_EN
      // Single-step: FETCH holds until a step pulse.
      apply_reset();
      write_word(4'd0, 8'h01);
      step_mode = 1'b1;
      start_run();
      for (int c = 1; c <= 4; c++) begin
         check_output($sformatf("step_hold_c%0d", c), 32'(observed()), 32'(fetch_ctl));
         if (c < 4) next_cycle();
      end
      step = 1'b1;
      next_cycle();
      step = 1'b0;
      check_output("step_exec", 32'(observed()), 32'(ctl(1, 0, 3'd0, 2'd0, 1, 0, 0)));
      next_cycle();
      next_cycle();
      check_output("step_hold2", 32'(observed()), 32'(fetch_ctl));
      check_output("step_hold2_pc", 32'(pc), 32'd1);
      step_mode = 1'b0;
      next_cycle();
      next_cycle();
      check_output("step_done", 32'(observed()), 32'(done_ctl));
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter PROG_DEPTH, default 16, meaning the number of program words; fixed at 16 because the address is 4 bits.
REQ-002 SHALL have parameter INSTR_W, default 8, meaning the instruction width in bits.
REQ-003 SHALL have port clk  in  1  system clock.
REQ-004 SHALL have port reset_n  in  1  reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port prog_we  in  1  program write strobe.
REQ-006 SHALL have port prog_addr  in  4  program write address.
REQ-007 SHALL have port prog_data  in  8  program write data.
REQ-008 SHALL have port start  in  1  run request, sampled only in IDLE.
REQ-009 SHALL have port bus_selector  out  3  bus source select.
REQ-010 SHALL have port alu_control  out  2  ALU op: 00 ADD, 01 OR, 10 XOR, 11 NOT.
REQ-011 SHALL have ports r1_enable, r2_enable and rout_enable  out  1 each  register load enables.
REQ-012 SHALL have port pc  out  4  current program counter.
REQ-013 SHALL have port busy  out  1  high in FETCH and EXEC.
REQ-014 SHALL have port done  out  1  one-cycle pulse after a HALT executes.

Function
REQ-015 Instruction encoding SHALL be: [7:6] opcode 00 MOVE, 01 ALU, 10 JUMP, 11 HALT.
REQ-016 MOVE SHALL drive bus_selector=[5:3] and decode dest [1:0] as 00 none, 01 R1, 10 R2, 11 R1+R2.
REQ-017 ALU SHALL drive alu_control=[1:0] and rout_enable=1.
REQ-018 JUMP SHALL load pc from [3:0] and assert no enables.
REQ-019 HALT SHALL assert no enables.
REQ-020 States SHALL be IDLE, FETCH, EXEC and DONE.
REQ-021 In IDLE with start=1, the sequencer SHALL set pc to 0 and go to FETCH.
REQ-022 FETCH SHALL latch mem[pc] into the instruction register and go to EXEC.
REQ-023 EXEC SHALL drive the decoded outputs for exactly one cycle.
REQ-024 On leaving EXEC, pc SHALL become target (JUMP) or pc+1 mod 16 (otherwise), and the next state SHALL be FETCH, or DONE on HALT.
REQ-025 DONE SHALL assert done=1 for one cycle, then go to IDLE; pc SHALL hold the HALT address.
REQ-026 Every instruction SHALL take 2 cycles, and outputs SHALL be decoded combinationally from state and the instruction register.
REQ-027 Outside EXEC, bus_selector, alu_control and all enables SHALL be 0.
REQ-028 pc SHALL wrap 15 to 0 without error; a JUMP to itself SHALL loop until reset.
REQ-029 prog_we SHALL write on the clock edge in IDLE or DONE, and SHALL be ignored in FETCH and EXEC.
REQ-030 prog_we and start together in IDLE SHALL perform both, and the first FETCH SHALL see the new word.
REQ-031 start SHALL be ignored outside IDLE.

Reset
REQ-032 With reset_n=0 at a clock edge: state IDLE, pc 0, instruction register 0xC0, all outputs 0, every program word 0xC0 (HALT).
REQ-033 Reset SHALL take priority over start and prog_we.
REQ-034 Reset asserted in any state, including mid-EXEC, SHALL give all-zero outputs from the next cycle.

Configuration
REQ-035 Macro SEQ_STEP_EN, when defined, SHALL add inputs step_mode and step (1 bit each).
REQ-036 With SEQ_STEP_EN defined and step_mode=1, FETCH SHALL hold (busy=1, outputs 0) until step=1, then proceed; step_mode=0 SHALL behave as if the macro were undefined.
REQ-037 With SEQ_STEP_EN undefined, those ports SHALL be absent and FETCH SHALL always take one cycle.

Structure
REQ-038 Package cpu_seq_pkg SHALL hold the opcode, dest and state constants, HALT_WORD=0xC0 and bus codes BUS_SW=000, BUS_ROUT=011, BUS_IMM3=101.
REQ-039 Sub-module seq_prog_mem SHALL implement the 16x8 flop array (synchronous write, asynchronous read, reset to HALT_WORD).

Verification
REQ-040 Program 01,2A,40,1A,41,19,43,19,C0, start -> EXEC cycles 2,4,...,16 show enables R1,R2,Rout,R2,Rout,R1,Rout,R1 with matching sel/alu; HALT in cycle 18; done=1 in cycle 19 only.
REQ-041 Post-reset start with no writes -> busy for 2 cycles, done in cycle 3, no enables ever.
REQ-042 Word 0=0x01, word 1=0x80 (JUMP 0), start -> r1_enable in every 4th cycle indefinitely; reset_n=0 -> IDLE, outputs 0 next cycle.
REQ-043 Program 15 MOVE words then JUMP 15 at word 15 -> pc counts 0..15 and stays 15; prog_we during busy -> memory unchanged.
REQ-044 SEQ_STEP_EN defined, step_mode=1 -> no EXEC until step pulse; each step pulse -> exactly one instruction executes.
